// File: rtl/bj_button_conditioner_pkg.sv
// bj_button_conditioner_pkg
//   Shared definitions for the blackjack button front end and the controller.
//   Button indices into the {stand,hit,deal} vectors, lockout length, and the
//   command arbiter (priority deal > stand > hit).
package bj_button_conditioner_pkg;

  localparam int BTN_DEAL  = 0;
  localparam int BTN_HIT   = 1;
  localparam int BTN_STAND = 2;
  localparam int BTN_COUNT = 3;

  // Cycles during which every command output is held low after an issued pulse.
  localparam int LOCKOUT_CYCLES = 2;

  typedef logic [BTN_COUNT-1:0] btn_vec_t;

  // Keep at most one request, highest priority first: deal, then stand, then hit.
  function automatic btn_vec_t bj_arbitrate(input btn_vec_t req);
    btn_vec_t gnt;
    gnt = '0;
    if (req[BTN_DEAL])       gnt[BTN_DEAL]  = 1'b1;
    else if (req[BTN_STAND]) gnt[BTN_STAND] = 1'b1;
    else if (req[BTN_HIT])   gnt[BTN_HIT]   = 1'b1;
    return gnt;
  endfunction

endpackage

// File: rtl/bj_button_conditioner_debounce.sv
// bj_debounce
//   One button channel: 2-flop synchroniser, debounce counter, debounced
//   level and rising-edge request.
//   Ports:
//     clk   in  system clock, rising edge
//     rst   in  asynchronous active-high reset
//     raw   in  raw button level, asynchronous, bouncy
//     level out debounced level
//     rise  out high for the one cycle after level goes 0->1 (unregistered;
//               the top registers it into the command output)
//   DEBOUNCE_CYCLES >= 2 and 2**CNT_W > DEBOUNCE_CYCLES are required.
module bj_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             lvl;
  logic             lvl_q;

  // cnt counts consecutive samples that disagree with lvl. On the
  // DEBOUNCE_CYCLES-th one lvl flips and cnt clears, so cnt tops out at
  // DEBOUNCE_CYCLES-1 and can never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      lvl   <= 1'b0;
      lvl_q <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      lvl_q <= lvl;
      if (sync[1] != lvl) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          cnt <= '0;
          lvl <= ~lvl;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign level = lvl;
  assign rise  = lvl & ~lvl_q;

endmodule

// File: rtl/bj_button_conditioner.sv
// bj_button_conditioner
//   Synchronises and debounces the deal/hit/stand push-buttons and emits one
//   single-cycle command pulse per accepted press.
//   Ports:
//     clk        in  system clock, rising edge
//     rst        in  asynchronous active-high reset
//     deal_raw   in  raw deal button (async, bouncy)
//     hit_raw    in  raw hit button
//     stand_raw  in  raw stand button
//     deal       out one-cycle pulse per accepted deal press
//     hit        out one-cycle pulse per accepted hit press
//     stand      out one-cycle pulse per accepted stand press
//     held       out debounced levels {stand,hit,deal}
//   Build option BJ_CMD_ARBITER_EN: commands become mutually exclusive
//   (deal > stand > hit, losers dropped) with a 2-cycle all-zero lockout after
//   each issued pulse. Undefined: channels are independent.
module bj_button_conditioner
  import bj_button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       deal_raw,
  input  logic       hit_raw,
  input  logic       stand_raw,
  output logic       deal,
  output logic       hit,
  output logic       stand,
  output logic [2:0] held
);

  btn_vec_t raw;
  btn_vec_t level;
  btn_vec_t rise;
  btn_vec_t pulse_q;

  always_comb begin
    raw            = '0;
    raw[BTN_DEAL]  = deal_raw;
    raw[BTN_HIT]   = hit_raw;
    raw[BTN_STAND] = stand_raw;
  end

  for (genvar i = 0; i < BTN_COUNT; i++) begin : g_btn
    bj_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw[i]),
      .level(level[i]),
      .rise (rise[i])
    );
  end

`ifdef BJ_CMD_ARBITER_EN
  // lock counts down the cycles left in the post-pulse lockout; any request
  // arriving meanwhile is discarded (rise is single-cycle, so it is lost).
  logic [1:0] lock;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_q <= '0;
      lock    <= '0;
    end else if (lock != 2'd0) begin
      pulse_q <= '0;
      lock    <= lock - 2'd1;
    end else begin
      pulse_q <= bj_arbitrate(rise);
      if (|rise) lock <= 2'(LOCKOUT_CYCLES);
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pulse_q <= '0;
    else     pulse_q <= rise;
  end
`endif

  assign deal  = pulse_q[BTN_DEAL];
  assign hit   = pulse_q[BTN_HIT];
  assign stand = pulse_q[BTN_STAND];
  assign held  = level;

endmodule

// File: tb/tb_bj_button_conditioner.sv
module tb_bj_button_conditioner;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       deal_raw = 1'b0, hit_raw = 1'b0, stand_raw = 1'b0;
  logic       deal, hit, stand;
  logic [2:0] held;

  always #10 clk = ~clk;

  bj_button_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .deal_raw(deal_raw), .hit_raw(hit_raw),
    .stand_raw(stand_raw), .deal(deal), .hit(hit), .stand(stand), .held(held)
  );

  int checks = 0, errors = 0;

  // Reference model: raw seen two edges late; level flips after D
  // consecutive disagreeing samples; pulse one edge after a 0->1 flip.
  int         cyc = 0;
  logic [2:0] r1, r2, lvl, rose, exp_p;
  int         run [3];
  int         last_issue;
  // observation
  int         pulses [3];
  int         last_rise_edge [3];
  int         last_lat [3];
  logic       both_seen, stand_held_seen;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    r1 = '0; r2 = '0; lvl = '0; rose = '0; exp_p = '0;
    for (int b = 0; b < 3; b++) run[b] = 0;
    last_issue = -100;
  endtask

  task automatic model_step();
    logic [2:0] raw, s, newrose;
    raw = {stand_raw, hit_raw, deal_raw};
`ifdef BJ_CMD_ARBITER_EN
    if (cyc - last_issue <= 2) exp_p = '0;
    else begin
      if (rose[0])      exp_p = 3'b001;
      else if (rose[2]) exp_p = 3'b100;
      else if (rose[1]) exp_p = 3'b010;
      else              exp_p = 3'b000;
      if (exp_p != 0) last_issue = cyc;
    end
`else
    exp_p = rose;
`endif
    s = r2;
    newrose = '0;
    for (int b = 0; b < 3; b++) begin
      if (s[b] != lvl[b]) begin
        run[b]++;
        if (run[b] == D) begin
          lvl[b] = ~lvl[b];
          run[b] = 0;
          newrose[b] = lvl[b];
        end
      end else run[b] = 0;
      if (raw[b] && !r1[b]) last_rise_edge[b] = cyc;
    end
    rose = newrose;
    r2 = r1;
    r1 = raw;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (clk && !rst) cyc++;
      if (rst) model_reset();
      else model_step();
      #1;
      chk("deal", deal, exp_p[0]);
      chk("hit", hit, exp_p[1]);
      chk("stand", stand, exp_p[2]);
      chk("held", held, lvl);
      if (deal)  begin pulses[0]++; last_lat[0] = cyc - last_rise_edge[0]; end
      if (hit)   begin pulses[1]++; last_lat[1] = cyc - last_rise_edge[1]; end
      if (stand) begin pulses[2]++; last_lat[2] = cyc - last_rise_edge[2]; end
      if (deal && hit) both_seen = 1'b1;
      if (held[2]) stand_held_seen = 1'b1;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    for (int b = 0; b < 3; b++) pulses[b] = 0;
    both_seen = 1'b0;
    stand_held_seen = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_outputs_clear", {deal, hit, stand, held}, 0);
  endtask

  initial begin
    clr();
    cycles(3);
    rst = 1'b0;

    // clean deal press, 5000 ns
    clr();
    deal_raw = 1'b1;
    cycles(250);
    chk("t2_deal_pulses", pulses[0], 1);
    chk("t2_deal_latency", last_lat[0], 6);
    chk("t2_held0", held[0], 1);
    deal_raw = 1'b0;
    cycles(10);

    // bouncing hit, then stable high
    clr();
    for (int i = 0; i < 4; i++) begin
      hit_raw = (i % 2 == 0);
      cycles(2);
    end
    hit_raw = 1'b1;
    cycles(20);
    chk("t3_hit_pulses", pulses[1], 1);
    chk("t3_hit_latency", last_lat[1], 6);
    hit_raw = 1'b0;
    cycles(10);

    // short stand glitch
    clr();
    stand_raw = 1'b1;
    cycles(3);
    stand_raw = 1'b0;
    cycles(15);
    chk("t4_stand_pulses", pulses[2], 0);
    chk("t4_stand_held", stand_held_seen, 0);

    // press, release, press
    clr();
    deal_raw = 1'b1; cycles(10);
    deal_raw = 1'b0; cycles(10);
    deal_raw = 1'b1; cycles(10);
    deal_raw = 1'b0; cycles(10);
    chk("t5_deal_pulses", pulses[0], 2);

    // simultaneous deal + hit
    clr();
    deal_raw = 1'b1; hit_raw = 1'b1;
    cycles(12);
`ifdef BJ_CMD_ARBITER_EN
    chk("t6_deal_pulses", pulses[0], 1);
    chk("t6_hit_pulses", pulses[1], 0);
`else
    chk("t6_deal_pulses", pulses[0], 1);
    chk("t6_hit_pulses", pulses[1], 1);
    chk("t6_same_cycle", both_seen, 1);
`endif
    deal_raw = 1'b0; hit_raw = 1'b0;
    cycles(12);

    // reset mid-count, buttons released during reset
    deal_raw = 1'b1; hit_raw = 1'b1; stand_raw = 1'b1;
    cycles(4);
    pulse_rst();
    deal_raw = 1'b0; hit_raw = 1'b0; stand_raw = 1'b0;
    cycles(2);
    rst = 1'b0;
    clr();
    cycles(15);
    chk("t1_no_pulse_after_rst", pulses[0] + pulses[1] + pulses[2], 0);

    // deal held through reset -> one fresh pulse after release
    deal_raw = 1'b1;
    cycles(20);
    pulse_rst();
    cycles(2);
    rst = 1'b0;
    clr();
    cycles(15);
    chk("held_through_rst_pulses", pulses[0], 1);
    deal_raw = 1'b0;
    cycles(12);

    // random bouncing on all three buttons
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(3) == 0) deal_raw  = ~deal_raw;
      if ($urandom_range(3) == 0) hit_raw   = ~hit_raw;
      if ($urandom_range(4) == 0) stand_raw = ~stand_raw;
      if (n == 1000) begin
        pulse_rst();
        cycles(1);
        rst = 1'b0;
      end
      cycles(1 + $urandom_range(2));
    end
    deal_raw = 1'b0; hit_raw = 1'b0; stand_raw = 1'b0;
    cycles(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
